// File: rtl/cap_tag_mem_responder.sv
// fta bus responder serving 128-bit capability tag lines from an on-chip RAM window.
// Define CAP_TAG_MEM_ZERO_INIT_EN to zero-fill the whole RAM after every reset.

package fta_bus_pkg;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_LOAD  = 4'd1,
    CMD_LOADZ = 4'd2,
    CMD_STORE = 4'd3,
    CMD_SWAP  = 4'd4,
    CMD_CAS   = 4'd5
  } fta_cmd_t;

  typedef struct packed {
    logic         cyc;
    fta_cmd_t     cmd;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         err;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage

module cap_tag_mem_responder
  import fta_bus_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h3FE00000,
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  fta_cmd_request128_t  req,
  output fta_cmd_response128_t resp,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StRead, StAck, StInit} state_t;

`ifdef CAP_TAG_MEM_ZERO_INIT_EN
  localparam state_t RstState = StInit;
`else
  localparam state_t RstState = StIdle;
`endif

  localparam logic [31:0] WinBytes = 32'(DEPTH * 16);
  localparam logic [1:0]  LatLast  = 2'(RD_LAT - 1);

  logic [127:0]  mem [DEPTH];
  state_t        state_q;
  logic [AW-1:0] line_q;
  logic [7:0]    tid_q;
  logic [31:0]   adr_q;
  logic [1:0]    lat_q;
  logic [127:0]  rd_q;
  logic          rty_pend_q;
  logic [7:0]    rty_tid_q;
  logic [31:0]   rty_adr_q;
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
  logic [AW-1:0] init_line_q;
`endif

  logic [32:0]   adr_off;
  logic          hit_win;
  logic [AW-1:0] line;
  logic          is_load;
  logic          is_store;
  logic          idle_hit;
  logic          ack_set;
  logic          err_set;
  logic          drop;
  logic          rty_fire;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_be;
  logic [127:0]  mem_wdata;

  // 33-bit subtract so addresses below BASE show up as a borrow
  assign adr_off  = {1'b0, req.adr} - {1'b0, BASE};
  assign hit_win  = req.cyc && !adr_off[32] && (adr_off[31:0] < WinBytes);
  assign line     = adr_off[AW+3:4];
  assign is_load  = (req.cmd == CMD_LOADZ);
  assign is_store = (req.cmd == CMD_STORE);
  assign idle_hit = hit_win && (state_q == StIdle);
  assign ack_set  = (idle_hit && is_store) || ((state_q == StRead) && (lat_q == LatLast));
  assign err_set  = idle_hit && !is_load && !is_store;
  assign drop     = hit_win && (state_q != StIdle);
  // A fresh drop replaces the pending retry instead of letting the older one fire
  assign rty_fire = rty_pend_q && !ack_set && !err_set && !drop;
  assign busy     = (state_q != StIdle);

  always_comb begin
    mem_we    = !rst && idle_hit && is_store;
    mem_addr  = line;
    mem_be    = req.sel;
    mem_wdata = req.data1;
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
    if (state_q == StInit) begin
      mem_we    = !rst;
      mem_addr  = init_line_q;
      mem_be    = '1;
      mem_wdata = '0;
    end
`endif
  end

  // RAM array is never reset so its contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 16; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    rd_q <= mem[line_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RstState;
      resp       <= '0;
      rty_pend_q <= 1'b0;
      lat_q      <= '0;
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
      init_line_q <= '0;
`endif
    end else begin
      resp <= '0;
      unique case (state_q)
        StIdle: begin
          if (hit_win) begin
            tid_q  <= req.tid;
            adr_q  <= req.adr;
            line_q <= line;
            if (is_load) begin
              state_q <= StRead;
              lat_q   <= '0;
            end else begin
              resp.ack <= is_store;
              resp.err <= !is_store;
              resp.tid <= req.tid;
              resp.adr <= req.adr;
              if (is_store) state_q <= StAck;
            end
          end
        end
        StRead: begin
          if (lat_q == LatLast) begin
            state_q  <= StAck;
            resp.ack <= 1'b1;
            resp.tid <= tid_q;
            resp.adr <= adr_q;
            resp.dat <= (RD_LAT == 1) ? mem[line_q] : rd_q;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        StAck: state_q <= StIdle;
        default: begin
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
          init_line_q <= init_line_q + 1'b1;
          if (init_line_q == AW'(DEPTH - 1)) state_q <= StIdle;
`else
          state_q <= StIdle;
`endif
        end
      endcase

      if (rty_fire) begin
        resp.rty <= 1'b1;
        resp.tid <= rty_tid_q;
        resp.adr <= rty_adr_q;
      end

      if (drop) begin
        rty_pend_q <= 1'b1;
        rty_tid_q  <= req.tid;
        rty_adr_q  <= req.adr;
      end else if (rty_fire) begin
        rty_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cap_tag_mem_responder.sv
// Bench for cap_tag_mem_responder: transaction-level model plus hand-computed spot checks.
// Set CAP_TAG_MEM_ZERO_INIT_EN to also exercise the zero-fill walk.

module tb_cap_tag_mem_responder;
  import fta_bus_pkg::*;

  localparam logic [31:0] BASE   = 32'h3FE00000;
  localparam int          DEPTH  = 8192;
  localparam int          RD_LAT = 1;
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
  localparam bit InitBusy = 1'b1;
`else
  localparam bit InitBusy = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  fta_cmd_request128_t  req;
  fta_cmd_response128_t resp;
  logic                 busy;

  cap_tag_mem_responder #(
    .BASE   (BASE),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .resp (resp),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- transaction-level model ----------------
  int                   cyc        = 0;
  int                   valid_from = 32'h7fffffff;
  int                   busy_from  = 0;
  int                   free_at    = 0;
  bit                   pend       = 1'b0;
  logic [7:0]           ptid;
  logic [31:0]          padr;
  fta_cmd_response128_t exp_r [int];
  logic [127:0]         mmem  [int];

  task automatic model_step();
    longint               a;
    int                   ln;
    bit                   hit, idle, dropped;
    fta_cmd_response128_t r;
    logic [127:0]         d;
    a   = longint'(req.adr);
    hit = req.cyc && (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 16);
    ln  = int'((a - longint'(BASE)) / 16);
    if (rst) begin
      exp_r.delete();
      pend       = 1'b0;
      busy_from  = cyc + 1;
      free_at    = cyc + 1;
      valid_from = cyc + 1;
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
      free_at = cyc + 1 + DEPTH;
      mmem.delete();
`endif
    end else begin
      idle    = (cyc >= free_at);
      dropped = hit && !idle;
      if (hit && idle) begin
        r     = '0;
        r.tid = req.tid;
        r.adr = req.adr;
        if (req.cmd == CMD_LOADZ) begin
          r.ack = 1'b1;
          r.dat = mmem.exists(ln) ? mmem[ln] : '0;
          exp_r[cyc + 1 + RD_LAT] = r;
          busy_from = cyc + 1;
          free_at   = cyc + 2 + RD_LAT;
        end else if (req.cmd == CMD_STORE) begin
          d = mmem.exists(ln) ? mmem[ln] : '0;
          for (int i = 0; i < 16; i++) if (req.sel[i]) d[8*i +: 8] = req.data1[8*i +: 8];
          mmem[ln] = d;
          r.ack = 1'b1;
          exp_r[cyc + 1] = r;
          busy_from = cyc + 1;
          free_at   = cyc + 2;
        end else begin
          r.err = 1'b1;
          exp_r[cyc + 1] = r;
        end
      end
      // retry goes out on the first response slot nobody else claimed
      if (pend && !dropped && !exp_r.exists(cyc + 1)) begin
        r     = '0;
        r.rty = 1'b1;
        r.tid = ptid;
        r.adr = padr;
        exp_r[cyc + 1] = r;
        pend = 1'b0;
      end
      if (dropped) begin
        pend = 1'b1;
        ptid = req.tid;
        padr = req.adr;
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  fta_cmd_response128_t e_r;
  logic                 e_b;

  initial forever begin
    @(negedge clk);
    if (cyc >= valid_from) begin
      e_r = exp_r.exists(cyc) ? exp_r[cyc] : '0;
      e_b = (cyc >= busy_from) && (cyc < free_at);
      n_cmp++;
      if (resp !== e_r || busy !== e_b) begin
        n_bad++;
        $display("FAIL cycle_%0d resp/busy: got %h/%b want %h/%b", cyc, resp, busy, e_r, e_b);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic put(input fta_cmd_t c, input logic [7:0] t, input logic [31:0] a,
                     input logic [15:0] s, input logic [127:0] d);
    @(negedge clk);
    req.cyc   = 1'b1;
    req.cmd   = c;
    req.tid   = t;
    req.adr   = a;
    req.sel   = s;
    req.data1 = d;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      req = '0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < DEPTH + 20) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 200'(busy), 200'(1'b0));
  endtask

  initial begin
    req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", 200'({busy, resp}), 200'({InitBusy, 171'd0}));
    wait_idle();

    // store full line, then load it back
    put(CMD_STORE, 8'd5, BASE + 32'h40, 16'hFFFF, {16{8'hA5}});
    idle(1);
    chk("t1_store_ack", 200'({resp.ack, resp.tid, resp.dat}), 200'({1'b1, 8'd5, 128'd0}));
    idle(1);
    put(CMD_LOADZ, 8'd6, BASE + 32'h40, 16'h0, 128'h0);
    idle(1 + RD_LAT);
    chk("t1_load_ack", 200'({resp.ack, resp.tid, resp.dat}), 200'({1'b1, 8'd6, {16{8'hA5}}}));

    // byte-lane masking
    put(CMD_STORE, 8'd7, BASE + 32'h80, 16'hFFFF, 128'h0);
    idle(2);
    put(CMD_STORE, 8'd8, BASE + 32'h80, 16'h0001, '1);
    idle(2);
    put(CMD_LOADZ, 8'd9, BASE + 32'h80, 16'h0, 128'h0);
    idle(1 + RD_LAT);
    chk("t2_masked", 200'(resp.dat), 200'(128'hFF));

    // back-to-back loads: second is retried
    put(CMD_LOADZ, 8'd1, BASE + 32'h40, 16'h0, 128'h0);
    put(CMD_LOADZ, 8'd2, BASE + 32'h80, 16'h0, 128'h0);
    idle(1);
    chk("t3_ack1", 200'({resp.ack, resp.rty, resp.tid}), 200'({1'b1, 1'b0, 8'd1}));
    idle(1);
    chk("t3_rty2", 200'({resp.ack, resp.rty, resp.tid, resp.adr}),
        200'({1'b0, 1'b1, 8'd2, BASE + 32'h80}));
    idle(1);
    put(CMD_LOADZ, 8'd2, BASE + 32'h80, 16'h0, 128'h0);
    idle(1 + RD_LAT);
    chk("t3_reissue", 200'({resp.ack, resp.tid, resp.dat}), 200'({1'b1, 8'd2, 128'hFF}));

    // window edges
    put(CMD_LOADZ, 8'd50, BASE - 32'd16, 16'h0, 128'h0);
    put(CMD_STORE, 8'd51, BASE + 32'(DEPTH * 16), 16'hFFFF, 128'h0);
    idle(3);
    chk("t4_busy", 200'(busy), 200'(1'b0));
    put(CMD_STORE, 8'd52, BASE + 32'(DEPTH * 16) - 32'd16, 16'hFFFF, 128'hC0FFEE);
    idle(2);
    put(CMD_LOADZ, 8'd53, BASE + 32'(DEPTH * 16) - 32'd16, 16'h0, 128'h0);
    idle(1 + RD_LAT);
    chk("t4_last_line", 200'(resp.dat), 200'(128'hC0FFEE));

    // unsupported command
    put(CMD_SWAP, 8'd9, BASE + 32'h40, 16'hFFFF, 128'h0);
    idle(1);
    chk("t5_err", 200'({resp.err, resp.ack, resp.tid, resp.adr}),
        200'({1'b1, 1'b0, 8'd9, BASE + 32'h40}));
    idle(1);
    put(CMD_LOADZ, 8'd10, BASE + 32'h40, 16'h0, 128'h0);
    idle(1 + RD_LAT);
    chk("t5_unchanged", 200'(resp.dat), 200'({16{8'hA5}}));

    // retry drains on the same edge a new load is accepted
    put(CMD_STORE, 8'd10, BASE + 32'hC0, 16'hFFFF, 128'h0123456789ABCDEF_FEDCBA9876543210);
    put(CMD_LOADZ, 8'd11, BASE + 32'h40, 16'h0, 128'h0);
    put(CMD_LOADZ, 8'd12, BASE + 32'hC0, 16'h0, 128'h0);
    idle(1);
    chk("drain_rty", 200'({resp.rty, resp.tid}), 200'({1'b1, 8'd11}));
    idle(1);
    chk("drain_ack", 200'({resp.ack, resp.tid, resp.dat}),
        200'({1'b1, 8'd12, 128'h0123456789ABCDEF_FEDCBA9876543210}));

    // only the last dropped requester is retried
    idle(1);
    put(CMD_LOADZ, 8'd20, BASE + 32'h40, 16'h0, 128'h0);
    put(CMD_LOADZ, 8'd21, BASE + 32'h80, 16'h0, 128'h0);
    put(CMD_LOADZ, 8'd22, BASE + 32'hC0, 16'h0, 128'h0);
    chk("ovr_ack", 200'({resp.ack, resp.tid}), 200'({1'b1, 8'd20}));
    idle(1);
    chk("ovr_quiet", 200'({resp.ack, resp.rty, resp.err}), 200'(3'b000));
    idle(1);
    chk("ovr_rty", 200'({resp.rty, resp.tid}), 200'({1'b1, 8'd22}));

    // reset mid-load kills the ack but keeps RAM
    idle(1);
    put(CMD_LOADZ, 8'd30, BASE + 32'h40, 16'h0, 128'h0);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", 200'({resp.ack, busy}), 200'(2'b00));
    rst = 1'b0;
    wait_idle();
    idle(2);
    put(CMD_LOADZ, 8'd31, BASE + 32'h40, 16'h0, 128'h0);
    idle(1 + RD_LAT);
`ifdef CAP_TAG_MEM_ZERO_INIT_EN
    chk("rst_ram_kept", 200'(resp.dat), 200'(128'h0));
`else
    chk("rst_ram_kept", 200'(resp.dat), 200'({16{8'hA5}}));
`endif

`ifdef CAP_TAG_MEM_ZERO_INIT_EN
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    put(CMD_LOADZ, 8'd40, BASE + 32'h100, 16'h0, 128'h0);
    idle(2);
    chk("init_rty", 200'({resp.rty, resp.tid}), 200'({1'b1, 8'd40}));
    wait_idle();
    put(CMD_LOADZ, 8'd41, BASE + 32'h100, 16'h0, 128'h0);
    idle(1 + RD_LAT);
    chk("init_zero", 200'(resp.dat), 200'(128'h0));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(100);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    begin
      int k = 0;
      while (busy === 1'b1 && k < DEPTH + 20) begin
        k++;
        @(negedge clk);
      end
      chk("init_len", 200'(k), 200'(DEPTH));
    end
`endif

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
